// File: rtl/lt_encoder_controller.sv
// rtl/lt_encoder_controller.sv - LT fountain encoder: buffers K source symbols, streams N_OUT XOR-coded symbols
// Optional LT_ENC_SYSTEMATIC_EN: first K outputs are the source symbols themselves.
module lt_encoder_controller #(
    parameter int          DATA_WIDTH = 32,
    parameter int          K          = 16,
    parameter int          N_OUT      = 24,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [7:0]            state_out,
    output logic                  busy,
    output logic                  err,
    input  logic [DATA_WIDTH-1:0] saxi_tdata,
    input  logic                  saxi_tvalid,
    input  logic                  saxi_tlast,
    output logic                  saxi_tready,
    output logic [DATA_WIDTH-1:0] maxi_tdata,
    output logic [16:0]           maxi_tuser,
    output logic                  maxi_tvalid,
    output logic                  maxi_tlast,
    input  logic                  maxi_tready
);
    localparam int IW = $clog2(K);
    localparam int OW = $clog2(N_OUT + 1);
    localparam logic [IW-1:0] W_LAST = IW'(K - 1);
    localparam logic [OW-1:0] O_LAST = OW'(N_OUT - 1);
    localparam logic [OW-1:0] K_O    = OW'(K);

    typedef enum logic [7:0] {
        IDLE        = 8'h01,
        LOAD        = 8'h02,
        SEED_ST     = 8'h04,
        XOR_READ    = 8'h08,
        XOR_ACC     = 8'h10,
        OUTPUT_WAIT = 8'h20,
        DONE        = 8'h40
    } state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] src_mem [K];
    logic [DATA_WIDTH-1:0] acc, rd_word;
    logic [15:0]           lfsr;
    logic [IW-1:0]         wcnt;
    logic [OW-1:0]         ocnt;
    logic [3:0]            rem;
    logic [16:0]           tuser_q;
    logic                  sys_sym;
    logic [IW-1:0]         rd_idx;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [3:0] degree(input logic [2:0] sel);
        logic [3:0] d;
        case (sel)
            3'd0:       d = 4'd1;
            3'd1, 3'd2: d = 4'd2;
            3'd3, 3'd4: d = 4'd3;
            3'd5, 3'd6: d = 4'd4;
            default:    d = 4'd8;
        endcase
        if (int'(d) > K) d = 4'(K);
        return d;
    endfunction

`ifdef LT_ENC_SYSTEMATIC_EN
    assign sys_sym = (ocnt < K_O);
`else
    assign sys_sym = 1'b0;
`endif

    // Systematic symbols walk the buffer in order and leave the LFSR untouched.
    assign rd_idx = sys_sym ? ocnt[IW-1:0] : lfsr[IW-1:0];

    assign state_out   = state;
    assign busy        = (state != IDLE);
    assign saxi_tready = (state == LOAD);
    assign maxi_tvalid = (state == OUTPUT_WAIT);
    assign maxi_tlast  = (state == OUTPUT_WAIT) && (ocnt == O_LAST);
    assign maxi_tdata  = acc;
    assign maxi_tuser  = tuser_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:        state_nx = start ? LOAD : IDLE;
            LOAD:        state_nx = (saxi_tvalid && wcnt == W_LAST) ? SEED_ST : LOAD;
            SEED_ST:     state_nx = XOR_READ;
            XOR_READ:    state_nx = XOR_ACC;
            XOR_ACC:     state_nx = (rem == 4'd1) ? OUTPUT_WAIT : XOR_READ;
            OUTPUT_WAIT: begin
                state_nx = OUTPUT_WAIT;
                if (maxi_tready) state_nx = (ocnt == O_LAST) ? DONE : SEED_ST;
            end
            DONE:        state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && saxi_tvalid) src_mem[wcnt] <= saxi_tdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr    <= SEED;
            wcnt    <= '0;
            ocnt    <= '0;
            err     <= 1'b0;
            acc     <= '0;
            rd_word <= '0;
            rem     <= '0;
            tuser_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lfsr <= SEED;
                        wcnt <= '0;
                        ocnt <= '0;
                        err  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (saxi_tvalid) begin
                        wcnt <= wcnt + 1'b1;
                        if (saxi_tlast != (wcnt == W_LAST)) err <= 1'b1;
                    end
                end
                SEED_ST: begin
                    acc <= '0;
                    if (sys_sym) begin
                        tuser_q <= {1'b1, 16'(ocnt)};
                        rem     <= 4'd1;
                    end else begin
                        tuser_q <= {1'b0, lfsr};
                        rem     <= degree(lfsr[2:0]);
                        lfsr    <= lfsr_next(lfsr);
                    end
                end
                XOR_READ: begin
                    rd_word <= src_mem[rd_idx];
                    if (!sys_sym) lfsr <= lfsr_next(lfsr);
                end
                XOR_ACC: begin
                    acc <= acc ^ rd_word;
                    rem <= rem - 4'd1;
                end
                OUTPUT_WAIT: begin
                    if (maxi_tready) ocnt <= ocnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lt_encoder_controller.sv
// tb/tb_lt_encoder_controller.sv - self-checking bench for lt_encoder_controller against a software LT model
module tb_lt_encoder_controller;
    localparam int          DW    = 8;
    localparam int          K     = 4;
    localparam int          N_OUT = 10;
    localparam logic [15:0] SEED  = 16'hACE1;
`ifdef LT_ENC_SYSTEMATIC_EN
    localparam bit SYS = 1'b1;
`else
    localparam bit SYS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, start;
    logic [7:0]    state_out;
    logic          busy, err;
    logic [DW-1:0] saxi_tdata;
    logic          saxi_tvalid, saxi_tlast, saxi_tready;
    logic [DW-1:0] maxi_tdata;
    logic [16:0]   maxi_tuser;
    logic          maxi_tvalid, maxi_tlast, maxi_tready;

    lt_encoder_controller #(.DATA_WIDTH(DW), .K(K), .N_OUT(N_OUT), .SEED(SEED)) dut (
        .clk(clk), .reset(reset), .start(start), .state_out(state_out), .busy(busy), .err(err),
        .saxi_tdata(saxi_tdata), .saxi_tvalid(saxi_tvalid), .saxi_tlast(saxi_tlast),
        .saxi_tready(saxi_tready), .maxi_tdata(maxi_tdata), .maxi_tuser(maxi_tuser),
        .maxi_tvalid(maxi_tvalid), .maxi_tlast(maxi_tlast), .maxi_tready(maxi_tready)
    );

    always #5 clk = ~clk;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [DW-1:0] src [K];
    logic [DW-1:0] exp_data [$];
    logic [16:0]   exp_user [$];
    int            exp_deg  [$];
    bit            aborted;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int degree_of(input logic [15:0] s);
        int d;
        case (s[2:0])
            3'd0:       d = 1;
            3'd1, 3'd2: d = 2;
            3'd3, 3'd4: d = 3;
            3'd5, 3'd6: d = 4;
            default:    d = 8;
        endcase
        return (d > K) ? K : d;
    endfunction

    task automatic build_model();
        logic [15:0]   s;
        logic [DW-1:0] a;
        int            d;
        s = SEED;
        exp_data.delete(); exp_user.delete(); exp_deg.delete();
        for (int j = 0; j < N_OUT; j++) begin
            if (SYS && j < K) begin
                exp_data.push_back(src[j]);
                exp_user.push_back({1'b1, 16'(j)});
                exp_deg.push_back(1);
            end else begin
                d = degree_of(s);
                exp_user.push_back({1'b0, s});
                exp_deg.push_back(d);
                s = step(s);
                a = '0;
                for (int r = 0; r < d; r++) begin
                    a ^= src[int'(s) % K];
                    s = step(s);
                end
                exp_data.push_back(a);
            end
        end
    endtask

    task automatic check_reset_values(input string p);
        chk({p, "_state"}, state_out, 8'h01);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_err"}, err, 0);
        chk({p, "_saxi_tready"}, saxi_tready, 0);
        chk({p, "_maxi_tvalid"}, maxi_tvalid, 0);
        chk({p, "_maxi_tlast"}, maxi_tlast, 0);
        chk({p, "_maxi_tdata"}, maxi_tdata, 0);
        chk({p, "_maxi_tuser"}, maxi_tuser, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_to_load_state", state_out, 8'h02);
        chk("start_to_saxi_tready", saxi_tready, 1);
        chk("start_busy", busy, 1);
    endtask

    task automatic load_block(input int bad_last, input bit gaps);
        int w = 0, cyc = 0;
        bit hs;
        while (w < K && cyc < 200) begin
            saxi_tvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            saxi_tdata  = src[w];
            saxi_tlast  = (bad_last >= 0) ? (w == bad_last) : (w == K - 1);
            hs = saxi_tvalid && saxi_tready;
            @(negedge clk);
            cyc++;
            if (hs) w++;
        end
        saxi_tvalid = 1'b0;
        saxi_tlast  = 1'b0;
        chk("load_words_accepted", w, K);
        if (!gaps) chk("load_cycles", cyc, K);
        chk("load_to_seed_state", state_out, 8'h04);
    endtask

    task automatic collect(input bit bp, input int abort_at);
        int            got = 0, cyc = 0, stall = 0, first_lat = -1;
        bit            holding = 0;
        logic [DW-1:0] hd;
        logic [16:0]   hu;
        logic          hl;
        bit            rdy;
        aborted = 0;
        while (got < N_OUT && cyc < 5000) begin
            if (abort_at >= 0 && got == abort_at && state_out == 8'h10) begin
                aborted = 1;
                break;
            end
            if (holding) begin
                chk("bp_valid_held", maxi_tvalid, 1);
                chk("bp_tdata_stable", maxi_tdata, hd);
                chk("bp_tuser_stable", maxi_tuser, hu);
                chk("bp_tlast_stable", maxi_tlast, hl);
            end
            if (maxi_tvalid) begin
                if (first_lat < 0) begin
                    first_lat = cyc;
                    chk("first_symbol_latency", cyc, 1 + 2 * exp_deg[0]);
                end
                if (bp && got == 2 && stall < 5) begin
                    rdy = 1'b0;
                    stall++;
                end else begin
                    rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                maxi_tready = rdy;
                if (rdy) begin
                    chk($sformatf("sym%0d_tdata", got), maxi_tdata, exp_data[got]);
                    chk($sformatf("sym%0d_tuser", got), maxi_tuser, exp_user[got]);
                    chk($sformatf("sym%0d_tlast", got), maxi_tlast, (got == N_OUT - 1));
                    got++;
                    holding = 0;
                end else begin
                    holding = 1;
                    hd = maxi_tdata; hu = maxi_tuser; hl = maxi_tlast;
                end
            end else begin
                maxi_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        maxi_tready = 1'b1;
        if (!aborted) begin
            chk("symbols_emitted", got, N_OUT);
            if (bp) chk("bp_stall_cycles", stall, 5);
            chk("done_state", state_out, 8'h40);
            chk("done_valid_low", maxi_tvalid, 0);
            @(negedge clk);
            chk("idle_after_done", state_out, 8'h01);
            chk("busy_low_in_idle", busy, 0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        saxi_tdata = '0; saxi_tvalid = 1'b0; saxi_tlast = 1'b0; maxi_tready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("idle_without_start", state_out, 8'h01);

        // Directed block with the reference sources.
        src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h44; src[3] = 8'h88;
        build_model();
        chk("model_first_tuser", exp_user[SYS ? K : 0], 17'h0ACE1);
        do_start();
        load_block(-1, 0);
        chk("load_err_clean", err, 0);
        collect(0, -1);
        chk("block1_err_clean", err, 0);

        // Random sources, random source gaps, random and forced backpressure.
        for (int i = 0; i < K; i++) src[i] = DW'($urandom);
        build_model();
        do_start();
        load_block(-1, 1);
        collect(1, -1);

        // Misplaced tlast sets err but encoding still completes.
        for (int i = 0; i < K; i++) src[i] = DW'($urandom);
        build_model();
        do_start();
        load_block(1, 0);
        chk("tlast_err_set", err, 1);
        collect(0, -1);
        chk("tlast_err_sticky", err, 1);
        do_start();
        chk("start_clears_err", err, 0);
        load_block(-1, 0);
        collect(0, -1);

        // Reset during XOR_ACC of symbol 3, then a clean rerun of the same block.
        do_start();
        load_block(-1, 0);
        collect(0, 3);
        chk("reached_abort_point", aborted, 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        reset = 1'b0;
        @(negedge clk);
        do_start();
        load_block(-1, 0);
        collect(0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/lt_encoder_controller.md
# lt_encoder_controller

Controller and datapath for the LT (fountain) encoder, the transmit-side counterpart of the LT decoder controller. It accepts one source block of K symbols over an AXI-Stream slave, buffers it, and generates N_OUT encoded symbols over an AXI-Stream master. Each encoded symbol is the XOR of d pseudo-randomly chosen source symbols. The 16-bit PRNG seed that reproduces the symbol's neighbour set is sent on tuser, so the decoder can regenerate the same neighbours.

## Interface
- DATA_WIDTH, 32, symbol width in bits
- K, 16, source symbols per block; power of two, 2..256
- N_OUT, 24, encoded symbols per block; must be ≥ K
- SEED, 16'hACE1, LFSR value loaded at each start; must be nonzero
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a block, sampled only in IDLE
- state_out  out  8  one-hot current state
- busy  out  1  high whenever not in IDLE
- err  out  1  sticky tlast-mismatch flag; cleared by reset or start
- saxi_tdata  in  DATA_WIDTH  source symbol
- saxi_tvalid  in  1  source valid
- saxi_tlast  in  1  last source symbol
- saxi_tready  out  1  high only in LOAD
- maxi_tdata  out  DATA_WIDTH  encoded symbol
- maxi_tuser  out  17  bit16 systematic flag; [15:0] seed or source index
- maxi_tvalid  out  1  encoded valid
- maxi_tlast  out  1  high with symbol N_OUT-1
- maxi_tready  in  1  downstream ready

## Operation
- States and one-hot codes: IDLE=1, LOAD=2, SEED=4, XOR_READ=8, XOR_ACC=16, OUTPUT_WAIT=32, DONE=64. An illegal code goes to IDLE on the next clock.
- IDLE:
  - On start: load LFSR=SEED, clear the word counter, output counter and err, then go to LOAD.
  - start is ignored in every other state.
- LOAD:
  - saxi_tready=1. Each tvalid&tready beat writes buf[wcnt] and increments wcnt.
  - If tlast is seen on a beat other than word K-1, or is absent on word K-1, set err. Continue loading until K words are stored.
  - After the K-th beat go to SEED.
- LFSR: 16-bit Galois, right-shift. On advance, if lsb=1 then s=(s>>1)^16'hB400, otherwise s=s>>1.
- SEED:
  - Latch tuser[15:0]=LFSR and tuser[16]=0.
  - Degree d=table[LFSR[2:0]] with table {1,2,2,3,3,4,4,8}, capped at K.
  - Clear the accumulator, set rem=d, advance the LFSR, then go to XOR_READ.
- XOR_READ: index i=LFSR[log2(K)-1:0]; register buf[i] and advance the LFSR.
- XOR_ACC:
  - acc ^= registered word; rem--.
  - If rem==0 go to OUTPUT_WAIT, otherwise go to XOR_READ.
  - Duplicate indices are allowed; they cancel in the XOR, and the decoder regenerates them identically.
- OUTPUT_WAIT:
  - maxi_tvalid=1, tdata=acc, tlast=(ocnt==N_OUT-1).
  - tdata, tuser and tlast stay stable until tvalid&tready.
  - On the handshake: ocnt++. If it was the last symbol go to DONE, otherwise go to SEED.
- DONE: one cycle, then IDLE. busy falls in IDLE.
- Reset in any state:
  - Next state is IDLE; all outputs return to reset values; buffer contents are don't-care.
  - A partially transferred symbol is discarded.

## Timing
- Reset values: state_out=8'h01, busy=0, err=0, saxi_tready=0, maxi_tvalid=0, maxi_tlast=0, maxi_tdata=0, maxi_tuser=0.
- Outputs are registered or decoded directly from state; there is no combinational path from maxi_tready to maxi_tvalid.
- start to saxi_tready high: 1 cycle.
- Last source beat to SEED: next cycle.
- Coded symbol latency from SEED entry to maxi_tvalid: 1+2d cycles.
- Minimum time per coded symbol: 2+2d cycles when maxi_tready is held high.
- With saxi_tvalid held high, LOAD takes exactly K cycles.

## Configuration
- LT_ENC_SYSTEMATIC_EN defined:
  - The first K output symbols are the source symbols in order, buf[j], with tuser={1'b1, j zero-extended}.
  - Each systematic symbol uses one cycle of XOR_READ plus XOR_ACC and does not advance the LFSR.
  - The remaining N_OUT-K symbols are LT coded, starting from LFSR=SEED.
- LT_ENC_SYSTEMATIC_EN undefined: all N_OUT symbols are LT coded and tuser[16] is always 0.

## Test plan
- LFSR step: SEED=16'hACE1 → first coded symbol has tuser=17'h0ACE1 and d=2; the first read index is taken from LFSR=16'hE270.
- Full block, macro off, K=4, DATA_WIDTH=8, sources 8'h11,8'h22,8'h44,8'h88, maxi_tready=1:
  - Output is exactly N_OUT symbols, each equal to the XOR of the indices predicted by a bit-accurate software LFSR model.
  - tlast is high only on the last symbol.
- Backpressure: maxi_tready low for 5 cycles during OUTPUT_WAIT → tvalid stays high and tdata/tuser/tlast hold; the symbol is accepted on the first ready cycle; no symbol is lost or duplicated.
- Macro on, same sources:
  - First 4 outputs are 8'h11,8'h22,8'h44,8'h88 with tuser 17'h10000..17'h10003.
  - The 5th output has tuser=17'h0ACE1.
- tlast errors:
  - saxi_tlast asserted on word 1 of 4 → err=1 at the end of LOAD; encoding still completes normally.
  - A new start clears err.
- Reset mid-block: assert reset during XOR_ACC of symbol 3 → next cycle state_out=8'h01 and all outputs are at reset values. A following start reproduces the full sequence from the first symbol.
